// File: rtl/rs232_rx_fifo_if.sv
// Bundle of the receiver-side capture handshake and the CPU-side FIFO port.
// The FIFO itself uses the slave modport; whoever drives the receiver and the CPU strobes uses master.
interface rs232_rx_fifo_if #(
   parameter int AW = 4
);
   logic [7:0] rx_data;
   logic       rx_rdy;
   logic       rx_done;
   logic       rd;
   logic       clr;
   logic [7:0] dout;
   logic       rdy;
   logic [AW:0] count;
   logic       ovf;

   modport slave (
      input  rx_data, rx_rdy, rd, clr,
      output rx_done, dout, rdy, count, ovf
   );

   modport master (
      output rx_data, rx_rdy, rd, clr,
      input  rx_done, dout, rdy, count, ovf
   );
endinterface

// File: rtl/rs232_rx_fifo.sv
// Receive byte FIFO: drains the RS-232 holding register through a one-cycle ACK handshake
// and presents a show-ahead head byte, fill count and sticky overflow flag to the CPU.
module rs232_rx_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   rs232_rx_fifo_if.slave  bus
);
   typedef enum logic {IDLE, ACK} state_t;

   localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

   state_t         state_q, state_d;
   logic           capture;
   logic [7:0]     mem_q [DEPTH];
   logic [AW-1:0]  wp_q, wp_d, rp_q, rp_d;
   logic [AW:0]    count_q, count_d;
   logic           ovf_q, ovf_d;
   logic           pop, push;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // ACK lasts one cycle and masks rx_rdy while the receiver is still clearing it.
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.rx_rdy) begin
               capture = 1'b1;
               state_d = ACK;
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
   always_comb begin
      pop     = bus.rd && (count_q != '0);
      push    = capture && ((count_q != FullCount) || pop);
      wp_d    = wp_q;
      rp_d    = rp_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (bus.clr) begin
         wp_d    = '0;
         rp_d    = '0;
         count_d = '0;
         ovf_d   = 1'b0;
      end else begin
         if (push) wp_d = wp_q + AW'(1);
         if (pop)  rp_d = rp_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
         if (capture && !push) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // Storage carries no reset; count gates every read of it.
   always_ff @(posedge clk) begin
      if (push && !bus.clr) mem_q[wp_q] <= bus.rx_data;
   end

   assign bus.rx_done = (state_q == ACK);
   assign bus.dout    = (count_q != '0) ? mem_q[rp_q] : 8'h00;
   assign bus.rdy     = (count_q != '0);
   assign bus.count   = count_q;
   assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_rs232_rx_fifo.sv
// Self-checking bench for rs232_rx_fifo: a queue scoreboard holds the bytes the FIFO should
// contain, and each scenario task drives the receiver/CPU side and compares inline.
module tb_rs232_rx_fifo;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   int   doneCount;
   logic prevDone;
   logic ovfModel;
   logic [7:0] q[$];

   rs232_rx_fifo_if #(.AW(AW)) bus ();

   rs232_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every rx_done high cycle is counted; two in a row means a stretched acknowledge.
   initial prevDone = 1'b0;
   always @(negedge clk) begin
      if (bus.rx_done === 1'b1) begin
         doneCount++;
         checks++;
         if (prevDone) begin
            failures++;
            $display("[TB] FAIL rx_done_width got=2+ cycles exp=1 cycle at %0t", $time);
         end
      end
      prevDone = (bus.rx_done === 1'b1);
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // One receiver byte: rx_rdy held through the capture edge and the ACK cycle.
   task automatic sendByte(input logic [7:0] d, input logic withRd, input logic withClr);
      logic [7:0] tmp;
      @(negedge clk);
      bus.rx_data = d;
      bus.rx_rdy  = 1'b1;
      bus.rd      = withRd;
      bus.clr     = withClr;
      if (withRd && q.size() > 0) begin
         checks++;
         if (bus.dout !== q[0]) begin
            failures++;
            $display("[TB] FAIL pop_with_capture got=%h exp=%h", bus.dout, q[0]);
         end
      end
      if (withClr) begin
         q.delete();
         ovfModel = 1'b0;
      end else begin
         if (withRd && q.size() > 0) tmp = q.pop_front();
         if (q.size() < DEPTH) q.push_back(d);
         else ovfModel = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.rd  = 1'b0;
      bus.clr = 1'b0;
      checks++;
      if (bus.rx_done !== 1'b1) begin
         failures++;
         $display("[TB] FAIL rx_done_after_capture got=%b exp=1", bus.rx_done);
      end
      checks++;
      if (bus.count !== (AW+1)'(q.size())) begin
         failures++;
         $display("[TB] FAIL count_after_capture got=%0d exp=%0d", bus.count, q.size());
      end
      @(posedge clk);
      #1;
      bus.rx_rdy = 1'b0;
   endtask

   // One CPU pop: the head byte is compared before the strobe takes effect.
   task automatic popByte(output logic [7:0] got);
      logic [7:0] exp;
      @(negedge clk);
      got = bus.dout;
      exp = (q.size() > 0) ? q.pop_front() : 8'h00;
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL pop_data got=%h exp=%h", got, exp);
      end
      bus.rd = 1'b1;
      @(posedge clk);
      #1;
      bus.rd = 1'b0;
      checks++;
      if (bus.count !== (AW+1)'(q.size())) begin
         failures++;
         $display("[TB] FAIL count_after_pop got=%0d exp=%0d", bus.count, q.size());
      end
   endtask

   task automatic clearFifo();
      @(negedge clk);
      bus.clr = 1'b1;
      @(posedge clk);
      #1;
      bus.clr = 1'b0;
      q.delete();
      ovfModel = 1'b0;
   endtask

   task automatic drain();
      logic [7:0] b;
      while (q.size() > 0) popByte(b);
   endtask

   task automatic test_reset();
      int d0;
      $display("[TB] test_reset");
      for (int i = 0; i < 5; i++) sendByte(8'h10 + 8'(i), 1'b0, 1'b0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      q.delete();
      ovfModel = 1'b0;
      #1;
      checks++;
      if (bus.rx_done !== 1'b0 || bus.rdy !== 1'b0 || bus.count !== '0 ||
          bus.dout !== 8'h00 || bus.ovf !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_state got=done%b rdy%b cnt%0d dout%h ovf%b exp=0 0 0 00 0",
                  bus.rx_done, bus.rdy, bus.count, bus.dout, bus.ovf);
      end
      bus.rx_data = 8'h5A;
      bus.rx_rdy  = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      d0 = doneCount;
      @(posedge clk);
      #1;
      checks++;
      if (bus.rx_done !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_release_done got=%b exp=1", bus.rx_done);
      end
      @(posedge clk);
      #1;
      bus.rx_rdy = 1'b0;
      q.push_back(8'h5A);
      repeat (3) @(negedge clk);
      checks++;
      if (doneCount - d0 != 1) begin
         failures++;
         $display("[TB] FAIL reset_release_pulses got=%0d exp=1", doneCount - d0);
      end
      checks++;
      if (bus.count !== 5'd1 || bus.dout !== 8'h5A) begin
         failures++;
         $display("[TB] FAIL reset_release_capture got=cnt%0d dout%h exp=cnt1 dout5a", bus.count, bus.dout);
      end
      drain();
   endtask

   task automatic test_single_handshake();
      int d0;
      $display("[TB] test_single_handshake");
      d0 = doneCount;
      sendByte(8'hA5, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      checks++;
      if (bus.count !== 5'd1 || bus.dout !== 8'hA5 || bus.rdy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL single_byte got=cnt%0d dout%h rdy%b exp=cnt1 douta5 rdy1",
                  bus.count, bus.dout, bus.rdy);
      end
      checks++;
      if (doneCount - d0 != 1) begin
         failures++;
         $display("[TB] FAIL single_pulses got=%0d exp=1", doneCount - d0);
      end
      drain();
   endtask

   task automatic test_fill_overflow_wrap();
      int d0;
      $display("[TB] test_fill_overflow_wrap");
      d0 = doneCount;
      for (int i = 0; i <= 16; i++) sendByte(8'(i), 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.count !== 5'd16 || bus.ovf !== 1'b1 || bus.dout !== 8'h00 || ovfModel !== 1'b1) begin
         failures++;
         $display("[TB] FAIL fill_state got=cnt%0d ovf%b dout%h exp=cnt16 ovf1 dout00",
                  bus.count, bus.ovf, bus.dout);
      end
      checks++;
      if (doneCount - d0 != 17) begin
         failures++;
         $display("[TB] FAIL fill_pulses got=%0d exp=17", doneCount - d0);
      end
      drain();
      @(negedge clk);
      checks++;
      if (bus.count !== '0 || bus.rdy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL empty_after_drain got=cnt%0d rdy%b exp=cnt0 rdy0", bus.count, bus.rdy);
      end
      for (int i = 0; i < 3; i++) sendByte(8'h20 + 8'(i), 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.count !== 5'd3 || bus.dout !== 8'h20) begin
         failures++;
         $display("[TB] FAIL wrap_head got=cnt%0d dout%h exp=cnt3 dout20", bus.count, bus.dout);
      end
      drain();
   endtask

   task automatic test_full_with_pop();
      logic [7:0] b;
      $display("[TB] test_full_with_pop");
      clearFifo();
      for (int i = 0; i < DEPTH; i++) sendByte(8'h40 + 8'(i), 1'b0, 1'b0);
      sendByte(8'hEE, 1'b1, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.count !== 5'd16 || bus.ovf !== 1'b0) begin
         failures++;
         $display("[TB] FAIL full_pop_state got=cnt%0d ovf%b exp=cnt16 ovf0", bus.count, bus.ovf);
      end
      b = 8'h00;
      while (q.size() > 0) popByte(b);
      checks++;
      if (b !== 8'hEE) begin
         failures++;
         $display("[TB] FAIL full_pop_last got=%h exp=ee", b);
      end
   endtask

   task automatic test_empty_pop();
      $display("[TB] test_empty_pop");
      @(negedge clk);
      bus.rd = 1'b1;
      checks++;
      if (bus.dout !== 8'h00) begin
         failures++;
         $display("[TB] FAIL empty_dout got=%h exp=00", bus.dout);
      end
      @(posedge clk);
      #1;
      bus.rd = 1'b0;
      checks++;
      if (bus.count !== '0 || bus.dout !== 8'h00 || bus.rdy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL empty_pop_state got=cnt%0d dout%h exp=cnt0 dout00", bus.count, bus.dout);
      end
      sendByte(8'h33, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.count !== 5'd1 || bus.dout !== 8'h33) begin
         failures++;
         $display("[TB] FAIL push_after_empty_pop got=cnt%0d dout%h exp=cnt1 dout33", bus.count, bus.dout);
      end
      drain();
   endtask

   task automatic test_clear_priority();
      logic [7:0] b;
      int d0;
      $display("[TB] test_clear_priority");
      for (int i = 0; i <= DEPTH; i++) sendByte(8'h60 + 8'(i), 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) popByte(b);
      @(negedge clk);
      checks++;
      if (bus.count !== 5'd7 || bus.ovf !== 1'b1) begin
         failures++;
         $display("[TB] FAIL clear_setup got=cnt%0d ovf%b exp=cnt7 ovf1", bus.count, bus.ovf);
      end
      d0 = doneCount;
      sendByte(8'h77, 1'b1, 1'b1);
      repeat (2) @(negedge clk);
      checks++;
      if (bus.count !== '0 || bus.ovf !== 1'b0 || bus.rdy !== 1'b0 || bus.dout !== 8'h00) begin
         failures++;
         $display("[TB] FAIL clear_state got=cnt%0d ovf%b rdy%b dout%h exp=cnt0 ovf0 rdy0 dout00",
                  bus.count, bus.ovf, bus.rdy, bus.dout);
      end
      checks++;
      if (doneCount - d0 != 1) begin
         failures++;
         $display("[TB] FAIL clear_pulses got=%0d exp=1", doneCount - d0);
      end
      sendByte(8'h12, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.count !== 5'd1 || bus.dout !== 8'h12) begin
         failures++;
         $display("[TB] FAIL clear_no_ghost got=cnt%0d dout%h exp=cnt1 dout12", bus.count, bus.dout);
      end
      drain();
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      doneCount   = 0;
      ovfModel    = 1'b0;
      rst_n       = 1'b0;
      bus.rx_data = 8'h00;
      bus.rx_rdy  = 1'b0;
      bus.rd      = 1'b0;
      bus.clr     = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      test_reset();
      test_single_handshake();
      test_fill_overflow_wrap();
      test_full_with_pop();
      test_empty_pop();
      test_clear_priority();

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
